// File: rtl/sequenciador_controle_pkg.sv
// Shared definitions for the SAP-1 control sequencer: opcodes, FSM states,
// control-word layout and small decode helpers.
package sequenciador_controle_pkg;

    localparam int unsigned OP_W = 4;
    localparam int unsigned T_W  = 6;

    localparam logic [OP_W-1:0] OP_LDA = 4'b0000;
    localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0010;
    localparam logic [OP_W-1:0] OP_OUT = 4'b1110;
    localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

    typedef enum logic [2:0] {
        ST_CARGA  = 3'd0,
        ST_T1     = 3'd1,
        ST_T2     = 3'd2,
        ST_T3     = 3'd3,
        ST_T4     = 3'd4,
        ST_T5     = 3'd5,
        ST_T6     = 3'd6,
        ST_HALTED = 3'd7
    } estado_t;

    // Control word; active-high strobes first, active-low after.
    typedef struct packed {
        logic cp;
        logic ep;
        logic ea;
        logic su;
        logic eu;
        logic n_lm;
        logic n_ce;
        logic n_l1;
        logic n_e1;
        logic n_la;
        logic n_lb;
        logic n_l0;
    } ctrl_t;

    localparam ctrl_t CTRL_INATIVO = 12'b00000_1111111;

    // One-hot T-state bus; zero outside T1..T6.
    function automatic logic [T_W-1:0] t_onehot(input estado_t e);
        case (e)
            ST_T1:   return 6'b000001;
            ST_T2:   return 6'b000010;
            ST_T3:   return 6'b000100;
            ST_T4:   return 6'b001000;
            ST_T5:   return 6'b010000;
            ST_T6:   return 6'b100000;
            default: return 6'b000000;
        endcase
    endfunction

    function automatic logic opcode_valido(input logic [OP_W-1:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
               (op == OP_OUT) || (op == OP_HLT);
    endfunction

endpackage

// File: rtl/sequenciador_controle_detector_borda.sv
// Step push-button conditioner: two-flop synchronizer followed by a
// registered rising-edge detector.
//  clk      in  system clock
//  clr      in  synchronous active-high reset
//  entrada  in  asynchronous level input (passo)
//  pulso    out one-cycle pulse per rising edge of entrada
module sequenciador_controle_detector_borda (
    input  logic clk,
    input  logic clr,
    input  logic entrada,
    output logic pulso
);

    logic [1:0] sinc;
    logic       sinc_ant;

    // Synchronize, remember previous synchronized level, register the edge.
    always_ff @(posedge clk) begin
        if (clr) begin
            sinc     <= 2'b00;
            sinc_ant <= 1'b0;
            pulso    <= 1'b0;
        end else begin
            sinc     <= {sinc[0], entrada};
            sinc_ant <= sinc[1];
            pulso    <= sinc[1] & ~sinc_ant;
        end
    end

endmodule

// File: rtl/sequenciador_controle.sv
// SAP-1 control sequencer: T-state FSM with load/execute gating, halt
// latching, optional early instruction end and single-step mode.
//  clk, clr            clock / synchronous active-high reset
//  run, manual, passo  execute enable, single-step mode, step button
//  opcode              IR[7:4]
//  t                   one-hot T-state (t[0]=T1)
//  cp,ep,ea,su,eu      active-high controls
//  n_lm..n_l0          active-low controls
//  n_hlt               low while halted
//  ilegal, fim_instr   one-cycle pulses (undefined opcode / instruction end)
//  n_instr             completed instruction counter
module sequenciador_controle
    import sequenciador_controle_pkg::*;
#(
    parameter bit          EARLY_END = 1'b0,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             run,
    input  logic             manual,
    input  logic             passo,
    input  logic [OP_W-1:0]  opcode,
    output logic [T_W-1:0]   t,
    output logic             cp,
    output logic             ep,
    output logic             ea,
    output logic             su,
    output logic             eu,
    output logic             n_lm,
    output logic             n_ce,
    output logic             n_l1,
    output logic             n_e1,
    output logic             n_la,
    output logic             n_lb,
    output logic             n_l0,
    output logic             n_hlt,
    output logic             ilegal,
    output logic             fim_instr,
    output logic [CNT_W-1:0] n_instr
);

    estado_t  estado, prox_c;
    ctrl_t    ctrl_c;
    logic     passo_pulso;
    logic     adv_c;
    logic     ultimo_c;
    logic     conta_c;
    logic     mem_op_c;
    logic     alu_op_c;

    sequenciador_controle_detector_borda u_detector_borda (
        .clk     (clk),
        .clr     (clr),
        .entrada (passo),
        .pulso   (passo_pulso)
    );

    // A cycle advances freely, or in single-step mode only on a step pulse.
    assign adv_c = ~manual | passo_pulso;

    assign alu_op_c = (opcode == OP_ADD) || (opcode == OP_SUB);
    assign mem_op_c = alu_op_c || (opcode == OP_LDA);

    // Last T-state of the current instruction.
    assign ultimo_c = (estado == ST_T6)
                   || (estado == ST_T5 && EARLY_END && opcode == OP_LDA)
                   || (estado == ST_T4 && (opcode == OP_HLT ||
                                           (EARLY_END && opcode == OP_OUT)));

    // State register and completed-instruction counter.
    always_ff @(posedge clk) begin
        if (clr) begin
            estado  <= ST_CARGA;
            n_instr <= '0;
        end else begin
            estado <= prox_c;
            if (conta_c) begin
                n_instr <= n_instr + CNT_W'(1);
            end
        end
    end

    // Next state and control decode; load strobes qualified by adv_c,
    // drive enables held for the whole state so a manual stall is safe.
    always_comb begin
        prox_c    = estado;
        ctrl_c    = CTRL_INATIVO;
        t         = t_onehot(estado);
        n_hlt     = 1'b1;
        ilegal    = 1'b0;
        fim_instr = 1'b0;
        conta_c   = 1'b0;

        case (estado)
            ST_CARGA: begin
                if (adv_c && run) prox_c = ST_T1;
            end
            ST_T1: begin
                ctrl_c.ep   = 1'b1;
                ctrl_c.n_lm = ~adv_c;
                if (adv_c) prox_c = ST_T2;
            end
            ST_T2: begin
                ctrl_c.cp = adv_c;
                if (adv_c) prox_c = ST_T3;
            end
            ST_T3: begin
                ctrl_c.n_ce = 1'b0;
                ctrl_c.n_l1 = ~adv_c;
                if (adv_c) prox_c = ST_T4;
            end
            ST_T4: begin
                if (mem_op_c) begin
                    ctrl_c.n_e1 = 1'b0;
                    ctrl_c.n_lm = ~adv_c;
                end else if (opcode == OP_OUT) begin
                    ctrl_c.ea   = 1'b1;
                    ctrl_c.n_l0 = ~adv_c;
                end else if (!opcode_valido(opcode)) begin
                    ilegal = adv_c;
                end
                if (adv_c) prox_c = ST_T5;
            end
            ST_T5: begin
                if (opcode == OP_LDA) begin
                    ctrl_c.n_ce = 1'b0;
                    ctrl_c.n_la = ~adv_c;
                end else if (alu_op_c) begin
                    ctrl_c.n_ce = 1'b0;
                    ctrl_c.n_lb = ~adv_c;
                    ctrl_c.su   = (opcode == OP_SUB);
                end
                if (adv_c) prox_c = ST_T6;
            end
            ST_T6: begin
                if (alu_op_c) begin
                    ctrl_c.eu   = 1'b1;
                    ctrl_c.n_la = ~adv_c;
                    ctrl_c.su   = (opcode == OP_SUB);
                end
            end
            ST_HALTED: begin
                n_hlt = 1'b0;
            end
            default: begin
                prox_c = ST_CARGA;
            end
        endcase

        // Instruction end: count it and pick the following state.
        if (adv_c && ultimo_c) begin
            fim_instr = 1'b1;
            conta_c   = 1'b1;
            if (estado == ST_T4 && opcode == OP_HLT) begin
                prox_c = ST_HALTED;
            end else begin
                prox_c = run ? ST_T1 : ST_CARGA;
            end
        end

        // Reset forces every output inactive in the same cycle.
        if (clr) begin
            ctrl_c    = CTRL_INATIVO;
            t         = '0;
            n_hlt     = 1'b1;
            ilegal    = 1'b0;
            fim_instr = 1'b0;
        end
    end

    assign cp   = ctrl_c.cp;
    assign ep   = ctrl_c.ep;
    assign ea   = ctrl_c.ea;
    assign su   = ctrl_c.su;
    assign eu   = ctrl_c.eu;
    assign n_lm = ctrl_c.n_lm;
    assign n_ce = ctrl_c.n_ce;
    assign n_l1 = ctrl_c.n_l1;
    assign n_e1 = ctrl_c.n_e1;
    assign n_la = ctrl_c.n_la;
    assign n_lb = ctrl_c.n_lb;
    assign n_l0 = ctrl_c.n_l0;

endmodule

// File: tb/tb_sequenciador_controle.sv
// Bench for sequenciador_controle: two instances (EARLY_END 0/1, counter
// widths 8/4) driven by the same inputs and compared every cycle against a
// step-counting reference model, plus directed scenarios with literal values.
module tb_sequenciador_controle;

    localparam logic [3:0] LDA = 4'h0;
    localparam logic [3:0] ADD = 4'h1;
    localparam logic [3:0] SUB = 4'h2;
    localparam logic [3:0] OUT = 4'he;
    localparam logic [3:0] HLT = 4'hf;

    logic       clk = 1'b0;
    logic       clr, run, manual, passo;
    logic [3:0] opcode;

    logic [5:0] t_o      [2];
    logic       cp_o     [2];
    logic       ep_o     [2];
    logic       ea_o     [2];
    logic       su_o     [2];
    logic       eu_o     [2];
    logic       n_lm_o   [2];
    logic       n_ce_o   [2];
    logic       n_l1_o   [2];
    logic       n_e1_o   [2];
    logic       n_la_o   [2];
    logic       n_lb_o   [2];
    logic       n_l0_o   [2];
    logic       n_hlt_o  [2];
    logic       ilegal_o [2];
    logic       fim_o    [2];
    logic [7:0] ni0;
    logic [3:0] ni1;

    int n_pass  = 0;
    int n_total = 0;
    bit en      = 1'b0;

    // Reference model state: step 0 = idle/load, 1..6 = T1..T6.
    int         step   [2];
    bit         halted [2];
    int         cnt    [2];
    logic [3:0] hist;   // passo samples, hist[0] newest

    always #5 clk = ~clk;

    sequenciador_controle #(.EARLY_END(1'b0), .CNT_W(8)) dut0 (
        .clk(clk), .clr(clr), .run(run), .manual(manual), .passo(passo),
        .opcode(opcode), .t(t_o[0]), .cp(cp_o[0]), .ep(ep_o[0]), .ea(ea_o[0]),
        .su(su_o[0]), .eu(eu_o[0]), .n_lm(n_lm_o[0]), .n_ce(n_ce_o[0]),
        .n_l1(n_l1_o[0]), .n_e1(n_e1_o[0]), .n_la(n_la_o[0]), .n_lb(n_lb_o[0]),
        .n_l0(n_l0_o[0]), .n_hlt(n_hlt_o[0]), .ilegal(ilegal_o[0]),
        .fim_instr(fim_o[0]), .n_instr(ni0)
    );

    sequenciador_controle #(.EARLY_END(1'b1), .CNT_W(4)) dut1 (
        .clk(clk), .clr(clr), .run(run), .manual(manual), .passo(passo),
        .opcode(opcode), .t(t_o[1]), .cp(cp_o[1]), .ep(ep_o[1]), .ea(ea_o[1]),
        .su(su_o[1]), .eu(eu_o[1]), .n_lm(n_lm_o[1]), .n_ce(n_ce_o[1]),
        .n_l1(n_l1_o[1]), .n_e1(n_e1_o[1]), .n_la(n_la_o[1]), .n_lb(n_lb_o[1]),
        .n_l0(n_l0_o[1]), .n_hlt(n_hlt_o[1]), .ilegal(ilegal_o[1]),
        .fim_instr(fim_o[1]), .n_instr(ni1)
    );

    logic [20:0] got_v [2];
    assign got_v[0] = {t_o[0], cp_o[0], ep_o[0], ea_o[0], su_o[0], eu_o[0],
                       n_lm_o[0], n_ce_o[0], n_l1_o[0], n_e1_o[0], n_la_o[0],
                       n_lb_o[0], n_l0_o[0], n_hlt_o[0], ilegal_o[0], fim_o[0]};
    assign got_v[1] = {t_o[1], cp_o[1], ep_o[1], ea_o[1], su_o[1], eu_o[1],
                       n_lm_o[1], n_ce_o[1], n_l1_o[1], n_e1_o[1], n_la_o[1],
                       n_lb_o[1], n_l0_o[1], n_hlt_o[1], ilegal_o[1], fim_o[1]};

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s at %0t: got %h, expected %h", nm, $time, got, want);
    endtask

    // Number of T-states an instruction occupies.
    function automatic int inst_len(input logic [3:0] op, input bit early);
        if (op == HLT) return 4;
        if (early && op == LDA) return 5;
        if (early && op == OUT) return 4;
        return 6;
    endfunction

    // A step pulse appears two cycles after the synchronizer sees a rise.
    function automatic bit cur_adv();
        return !manual || (hist[2] && !hist[3]);
    endfunction

    function automatic logic [20:0] expected(input int st, input bit hl, input logic [3:0] op,
                                             input bit adv, input bit early, input bit rst);
        logic [5:0] tv;
        logic c_cp, c_ep, c_ea, c_su, c_eu;
        logic c_lm, c_ce, c_l1, c_e1, c_la, c_lb, c_l0;
        logic hlt, il, fim;
        bit   alu, mem;
        tv = 6'd0;
        c_cp = 0; c_ep = 0; c_ea = 0; c_su = 0; c_eu = 0;
        c_lm = 1; c_ce = 1; c_l1 = 1; c_e1 = 1; c_la = 1; c_lb = 1; c_l0 = 1;
        hlt = 1; il = 0; fim = 0;
        alu = (op == ADD) || (op == SUB);
        mem = alu || (op == LDA);
        if (!rst && hl) begin
            hlt = 0;
        end else if (!rst && st > 0) begin
            tv = 6'd1 << (st - 1);
            case (st)
                1: begin c_ep = 1; c_lm = !adv; end
                2: c_cp = adv;
                3: begin c_ce = 0; c_l1 = !adv; end
                4: begin
                    if (mem) begin c_e1 = 0; c_lm = !adv; end
                    else if (op == OUT) begin c_ea = 1; c_l0 = !adv; end
                    else if (op != HLT) il = adv;
                end
                5: begin
                    if (op == LDA) begin c_ce = 0; c_la = !adv; end
                    else if (alu) begin c_ce = 0; c_lb = !adv; c_su = (op == SUB); end
                end
                6: if (alu) begin c_eu = 1; c_la = !adv; c_su = (op == SUB); end
                default: ;
            endcase
            fim = adv && (st == inst_len(op, early));
        end
        return {tv, c_cp, c_ep, c_ea, c_su, c_eu, c_lm, c_ce, c_l1, c_e1,
                c_la, c_lb, c_l0, hlt, il, fim};
    endfunction

    // Model update on each active edge, from the inputs the DUT sees.
    initial begin
        hist = 4'd0;
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                if (clr) begin
                    step[i] = 0; halted[i] = 0; cnt[i] = 0;
                end else if (!halted[i] && cur_adv()) begin
                    if (step[i] == 0) begin
                        if (run) step[i] = 1;
                    end else if (step[i] == inst_len(opcode, i == 1)) begin
                        cnt[i]++;
                        if (opcode == HLT) begin
                            halted[i] = 1; step[i] = 0;
                        end else begin
                            step[i] = run ? 1 : 0;
                        end
                    end else begin
                        step[i]++;
                    end
                end
            end
            hist = clr ? 4'd0 : {hist[2:0], passo};
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (en) begin
                for (int i = 0; i < 2; i++) begin
                    cmp($sformatf("outputs_e%0d", i), 32'(got_v[i]),
                        32'(expected(step[i], halted[i], opcode, cur_adv(), i == 1, clr)));
                end
                cmp("n_instr_e0", 32'(ni0), 32'(cnt[0] % 256));
                cmp("n_instr_e1", 32'(ni1), 32'(cnt[1] % 16));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
    endtask

    initial begin
        int cp_n;
        int r;
        clr = 1'b1; run = 1'b0; manual = 1'b0; passo = 1'b0; opcode = LDA;
        tick(1);
        en  = 1'b1;
        clr = 1'b0;

        // Load mode stays idle.
        tick(20);
        @(negedge clk);
        cmp("idle_t", 32'(t_o[0]), 32'h0);
        cmp("idle_n_lm", 32'(n_lm_o[0]), 32'h1);
        cmp("idle_n_instr", 32'(ni0), 32'h0);

        // ADD repeating, six T-states each.
        run = 1'b1; opcode = ADD;
        tick(6);
        @(negedge clk);
        cmp("add_t6", 32'(t_o[0]), 32'h20);
        cmp("add_t6_eu", 32'(eu_o[0]), 32'h1);
        cmp("add_t6_n_la", 32'(n_la_o[0]), 32'h0);
        tick(7);
        @(negedge clk);
        cmp("add_two_done", 32'(ni0), 32'h2);
        cmp("add_back_t1", 32'(t_o[0]), 32'h01);

        // OUT with early end on dut1 only.
        do_clr();
        opcode = OUT; run = 1'b1;
        tick(4);
        @(negedge clk);
        cmp("out_t4_e1", 32'(t_o[1]), 32'h08);
        cmp("out_n_l0_e1", 32'(n_l0_o[1]), 32'h0);
        cmp("out_fim_e1", 32'(fim_o[1]), 32'h1);
        cmp("out_fim_e0", 32'(fim_o[0]), 32'h0);
        tick(1);
        @(negedge clk);
        cmp("out_wrap_e1", 32'(t_o[1]), 32'h01);
        cmp("out_cnt_e1", 32'(ni1), 32'h1);
        cmp("out_t5_e0", 32'(t_o[0]), 32'h10);

        // HLT latches until clr.
        do_clr();
        opcode = HLT; run = 1'b1;
        tick(5);
        @(negedge clk);
        cmp("hlt_n_hlt", 32'(n_hlt_o[0]), 32'h0);
        cmp("hlt_t", 32'(t_o[0]), 32'h0);
        cmp("hlt_cnt", 32'(ni0), 32'h1);
        for (int i = 0; i < 6; i++) begin
            run = 1'($urandom_range(0, 1));
            passo = ~passo;
            tick(1);
        end
        @(negedge clk);
        cmp("hlt_stays", 32'(n_hlt_o[1]), 32'h0);
        do_clr();
        passo = 1'b0;
        @(negedge clk);
        cmp("hlt_cleared", 32'(n_hlt_o[0]), 32'h1);

        // Single-step mode: stall at T2 then exactly one cp per step.
        manual = 1'b1; run = 1'b1; opcode = LDA;
        for (int k = 0; k < 2; k++) begin
            passo = 1'b1; tick(3);
            passo = 1'b0; tick(3);
        end
        tick(10);
        @(negedge clk);
        cmp("step_stall_t2", 32'(t_o[0]), 32'h02);
        cmp("step_stall_cp", 32'(cp_o[0]), 32'h0);
        passo = 1'b1;
        cp_n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (cp_o[0] === 1'b1) cp_n++;
            if (i == 2) passo = 1'b0;
        end
        cmp("step_one_cp", 32'(cp_n), 32'h1);
        cmp("step_t3", 32'(t_o[0]), 32'h04);

        // run dropped at T3 of SUB: instruction completes, then idle.
        manual = 1'b0;
        do_clr();
        opcode = SUB; run = 1'b1;
        tick(3);
        run = 1'b0;
        tick(3);
        @(negedge clk);
        cmp("sub_t6", 32'(t_o[0]), 32'h20);
        cmp("sub_su", 32'(su_o[0]), 32'h1);
        tick(1);
        @(negedge clk);
        cmp("sub_idle", 32'(t_o[0]), 32'h0);
        cmp("sub_cnt", 32'(ni0), 32'h1);

        // Undefined opcode pulses ilegal at T4 only.
        do_clr();
        opcode = 4'h5; run = 1'b1;
        tick(4);
        @(negedge clk);
        cmp("ilegal_t4", 32'(ilegal_o[0]), 32'h1);
        tick(1);
        @(negedge clk);
        cmp("ilegal_t5", 32'(ilegal_o[0]), 32'h0);

        // Randomized run; opcode only changes outside T4..T6.
        for (int c = 0; c < 3000; c++) begin
            clr    = ($urandom_range(0, 119) == 0);
            run    = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 39) == 0) manual = ~manual;
            if ($urandom_range(0, 2) == 0) passo = ~passo;
            if (step[0] < 4 && step[1] < 4) begin
                r = $urandom_range(0, 15);
                if (r < 12) begin
                    case (r % 4)
                        0: opcode = LDA;
                        1: opcode = ADD;
                        2: opcode = SUB;
                        default: opcode = OUT;
                    endcase
                end else if (r == 12) begin
                    opcode = HLT;
                end else begin
                    opcode = 4'($urandom_range(0, 15));
                end
            end
            tick(1);
        end
        @(negedge clk);
        en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
